image_uart_tx: RTL and testbench
================================

// Module: image_uart_tx
// PURPOSE
//   Streams processed image bytes out of the SYSTEM data memory over a UART 8N1 serial line.
//   It is the output side of the image datapath: the processor writes the result image to
//   data memory, and this block reads it back byte by byte and transmits it to the host PC.
//   It is a memory read master plus a serial transmitter, driven by a start/busy/done handshake.
// PARAMETERS
//   ADDR_W        16   data-memory address width
//   LEN_W         16   byte-count width
//   CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); legal range >= 2
// PORTS
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   start      in   1       1-cycle request to begin a transfer; honoured only when busy=0
//   base_addr  in   ADDR_W  first data-memory address; sampled on the accepted start
//   num_bytes  in   LEN_W   number of bytes to send; sampled on the accepted start
//   mem_addr   out  ADDR_W  data-memory read address
//   mem_rd_en  out  1       read strobe; mem_rdata is valid on the cycle after the strobe
//   mem_rdata  in   8       data-memory read data (synchronous, 1-cycle latency)
//   tx         out  1       serial line; idle high
//   busy       out  1       high from the cycle after start is accepted until done
//   done       out  1       1-cycle pulse when the transfer completes
// BEHAVIOUR
//   Reset: tx=1, busy=0, done=0, mem_rd_en=0, mem_addr=0, state=IDLE.
//     Reset takes effect immediately, including mid-frame; tx returns high with no partial stop bit.
//   States: IDLE -> FETCH -> WAIT -> START -> DATA -> STOP -> (FETCH | DONE) -> IDLE.
//   IDLE
//     On start=1: latch addr<=base_addr and remaining<=num_bytes; go to FETCH (busy=1 next cycle).
//     start is ignored while busy=1.
//   FETCH
//     If remaining==0: go to DONE without driving tx.
//     Otherwise assert mem_rd_en=1 for exactly 1 cycle with mem_addr=addr; go to WAIT.
//   WAIT
//     Capture mem_rdata into the shift register; decrement remaining; go to START.
//   START   tx=0 for CLKS_PER_BIT cycles.
//   DATA    8 bits, LSB first, each held for CLKS_PER_BIT cycles.
//   STOP
//     tx=1 for CLKS_PER_BIT cycles.
//     Then: addr<=addr+1 (wraps modulo 2^ADDR_W); go to FETCH if remaining!=0, else DONE.
//   DONE
//     done=1 for 1 cycle, busy=0 in the same cycle; go to IDLE.
//     A start asserted in the DONE cycle is ignored.
//   Baud counter: counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
//     Every bit lasts exactly CLKS_PER_BIT cycles.
//   Per-byte cost: 10*CLKS_PER_BIT + 2 cycles.
//     Back-to-back bytes have a 2-cycle idle-high gap before the next start bit (FETCH+WAIT).
//   mem_rd_en is 0 in every state except FETCH; mem_addr holds its last value otherwise.
//   busy is high only in FETCH..STOP; tx is high in all states except START and DATA.
// TESTING (CLKS_PER_BIT=4, memory model with 1-cycle read latency)
//   1. Reset, idle 20 cycles -> tx=1, busy=0, done=0, mem_rd_en=0 throughout.
//   2. start with base=0x0010, n=1, mem[0x10]=0xA5 -> one read at 0x0010.
//      Then tx low 4 cycles, bits 1,0,1,0,0,1,0,1 x4 cycles each, high 4 cycles.
//      done pulses 42 cycles after the accepted start.
//   3. base=0x0000, n=3, mem={0x00,0xFF,0x3C} -> reads at 0,1,2.
//      Three decoded frames 0x00,0xFF,0x3C; 2-cycle high gap between frames; one done pulse.
//   4. n=0 -> busy for 1 cycle; done pulses; no mem_rd_en; tx stays 1.
//   5. base=0xFFFF, n=2 -> reads at 0xFFFF then 0x0000.
//      Second start pulse issued mid-transfer is ignored (exactly 2 frames sent).
//   6. rst_n low during the DATA bit 3 of a frame -> tx=1 and busy=0 asynchronously.
//      After release, a new start (n=1, 0x5A) transmits a correct frame.

Source files
------------

// File: rtl/image_uart_tx_if.sv
// Bus bundle for image_uart_tx: start/busy/done control, data-memory read port
// and the serial line. The transmitter uses the slave view; whoever issues
// transfers and models the memory uses the master view.
interface image_uart_tx_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_bytes;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              tx;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, num_bytes, mem_rdata,
    output mem_addr, mem_rd_en, tx, busy, done
  );

  modport master (
    output start, base_addr, num_bytes, mem_rdata,
    input  mem_addr, mem_rd_en, tx, busy, done
  );
endinterface

// File: rtl/image_uart_tx.sv
// image_uart_tx: reads num_bytes bytes from data memory starting at base_addr
// and sends each one as a UART 8N1 frame (LSB first, idle high).
//
// Handshake: start is a one-cycle request, accepted only in IDLE (busy=0).
// busy is high from the cycle after acceptance through the last stop bit;
// done pulses for one cycle (with busy already low) when the transfer ends.
// The memory read is a one-cycle strobe; mem_rdata is valid the cycle after.
module image_uart_tx #(
  parameter int ADDR_W       = 16,
  parameter int LEN_W        = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                rst_n,
  image_uart_tx_if.slave      bus,
  output logic [2:0]          dbg_state_o
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;         // address of the next byte to fetch
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;   // last address presented to memory
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [7:0]        shift_q, shift_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              bit_end;
  logic              rd_fire;

  assign bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign rd_fire = (state_q == S_FETCH) && (remaining_q != '0);

  // Next-state and datapath update for the fetch/serialise sequence
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.num_bytes;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else begin
          rd_addr_d = addr_q;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        shift_d     = bus.mem_rdata;
        remaining_d = remaining_q - LEN_W'(1);
        baud_d      = '0;
        state_d     = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (remaining_q != '0) ? S_FETCH : S_DONE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      baud_q      <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
    end
  end

  // Outputs decoded from state so reset forces tx high immediately
  always_comb begin
    bus.mem_rd_en = rd_fire;
    bus.mem_addr  = rd_fire ? addr_q : rd_addr_q;
    bus.busy      = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                    (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_STOP);
    bus.done      = (state_q == S_DONE);
    case (state_q)
      S_START: bus.tx = 1'b0;
      S_DATA:  bus.tx = shift_q[0];
      default: bus.tx = 1'b1;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_image_uart_tx.sv
// Bench for image_uart_tx with CLKS_PER_BIT=4 and a 1-cycle-latency memory.
// Expected frames, read addresses and done cycles are queued by the driver;
// independent monitors decode tx, watch the read strobe and the done pulse.
`timescale 1ns/1ps
module tb_image_uart_tx;
  localparam int CPB = 4;
  localparam int AW  = 16;
  localparam int LW  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  image_uart_tx_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
  logic [2:0] dbg_state;

  image_uart_tx #(.ADDR_W(AW), .LEN_W(LW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  // memory model
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // frame monitor: checks exact bit timing and decodes bytes
  int ph = 0, mcnt = 0, bitn = 0, gap_cnt = 0;
  bit in_gap = 0;
  logic cur_bit;
  logic [7:0] rx_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; mcnt = 0; in_gap = 0;
    end else begin
      case (ph)
        0: begin
          if (bus.tx == 1'b0) begin
            if (in_gap) check("frame_gap", gap_cnt, 2);
            in_gap = 0; ph = 1; mcnt = 1;
          end else if (in_gap) begin
            if (bus.busy) gap_cnt++;
            else in_gap = 0;
          end
        end
        1: begin
          check("start_bit", bus.tx, 1'b0);
          mcnt++;
          if (mcnt == CPB) begin ph = 2; mcnt = 0; bitn = 0; end
        end
        2: begin
          if (mcnt == 0) cur_bit = bus.tx;
          else check("data_hold", bus.tx, cur_bit);
          mcnt++;
          if (mcnt == CPB) begin
            rx_byte[bitn] = cur_bit;
            mcnt = 0; bitn++;
            if (bitn == 8) ph = 3;
          end
        end
        default: begin
          check("stop_bit", bus.tx, 1'b1);
          mcnt++;
          if (mcnt == CPB) begin
            if (exp_q.size() == 0) check("unexpected_frame", rx_byte, 9'h100);
            else check("frame_byte", rx_byte, exp_q.pop_front());
            ph = 0; in_gap = 1; gap_cnt = 0;
          end
        end
      endcase
    end
  end

  // read-address monitor
  always @(negedge clk) begin
    if (rst_n && bus.mem_rd_en) begin
      if (exp_addr_q.size() == 0) check("unexpected_read", bus.mem_addr, 17'h10000);
      else check("read_addr", bus.mem_addr, exp_addr_q.pop_front());
    end
  end

  // done monitor: timing relative to the accepting edge, busy low alongside
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      check("done_busy_low", bus.busy, 1'b0);
      if (exp_done_q.size() == 0) check("unexpected_done", cyc, 32'hFFFF_FFFF);
      else check("done_cycle", cyc, exp_done_q.pop_front());
    end
  end

  // driver: one transfer, start held 'hold' cycles, optional stray start at 'extra_at'
  task automatic run_xfer(input logic [AW-1:0] base, input logic [LW-1:0] n,
                          input int hold, input int extra_at);
    int k, i, bcnt, lat;
    bit seen;
    logic [AW-1:0] a;
    @(negedge clk);
    k   = cyc + 1;
    lat = (n == 0) ? 1 : 42 * int'(n);
    for (int j = 0; j < int'(n); j++) begin
      a = base + AW'(j);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
    exp_done_q.push_back(k + lat);
    bus.base_addr = base;
    bus.num_bytes = n;
    bus.start = 1'b1;
    i = 0; bcnt = 0; seen = 0;
    while ((!seen || i < hold) && i < 3000) begin
      @(negedge clk);
      i++;
      if (i == hold) bus.start = 1'b0;
      if (extra_at > 0 && i == extra_at) begin
        bus.base_addr = 16'h1234; bus.num_bytes = 16'd5; bus.start = 1'b1;
      end
      if (extra_at > 0 && i == extra_at + 1) bus.start = 1'b0;
      if (!seen) begin
        if (bus.busy) bcnt++;
        if (bus.done) seen = 1;
      end
    end
    bus.start = 1'b0;
    check("done_seen", seen, 1'b1);
    check("busy_cycles", bcnt, lat);
    repeat (3) @(negedge clk);
    check("idle_after", {bus.busy, bus.tx}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_bytes = '0;
    mem[16'h0010] = 8'hA5;
    mem[16'h0000] = 8'h00;
    mem[16'h0001] = 8'hFF;
    mem[16'h0002] = 8'h3C;
    mem[16'hFFFF] = 8'h81;
    mem[16'h0040] = 8'h77;
    mem[16'h0050] = 8'h5A;

    // 1: reset values and quiet idle
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.tx, bus.busy, bus.done, bus.mem_rd_en}, 4'b1000);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_outputs", {bus.tx, bus.busy, bus.done, bus.mem_rd_en}, 4'b1000);
    end

    // 2: single byte 0xA5 from 0x0010, done 42 cycles after accept
    run_xfer(16'h0010, 16'd1, 1, 0);
    // 3: three bytes from 0x0000
    run_xfer(16'h0000, 16'd3, 1, 0);
    // 4: zero-length; start held through FETCH and DONE must not restart
    run_xfer(16'h0000, 16'd0, 3, 0);
    // 5: address wrap 0xFFFF -> 0x0000 with a stray start mid-transfer
    run_xfer(16'hFFFF, 16'd2, 1, 50);

    // 6: reset during data bit 3, then a clean frame
    @(negedge clk);
    exp_addr_q.push_back(16'h0040);
    bus.base_addr = 16'h0040;
    bus.num_bytes = 16'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {bus.tx, bus.busy, bus.done, bus.mem_rd_en}, 4'b1000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_xfer(16'h0050, 16'd1, 1, 0);

    repeat (10) @(negedge clk);
    check("frames_left", exp_q.size(), 0);
    check("reads_left", exp_addr_q.size(), 0);
    check("dones_left", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
